// File: rtl/sender_rsa.sv
// OT sender: masks two messages with RSA-derived keys k_i = (v - x_i)^d mod N using one shared exponentiator.
// Define SENDER_RSA_HOLD_RESULT_EN to keep mod_res0/mod_res1 valid after DONE instead of zeroing them.

module RL_binary (
  input  logic        clk,
  input  logic        rstn,
  input  logic        md_start,
  input  logic [31:0] base,
  input  logic [31:0] exp,
  input  logic [31:0] modulus,
  output logic [31:0] r,
  output logic        md_end
);

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_END} md_state_t;

  md_state_t   state, state_nxt;
  logic [31:0] b_q, e_q, n_q, acc_r, acc_b, step_r, step_b;
  logic [4:0]  cnt;
  logic        accept, last_bit;

  // One bit of an interleaved modular multiply: acc = 2*acc (+a) mod n, with acc, a < n.
  function automatic logic [31:0] mul_step(input logic [31:0] acc, input logic [31:0] a,
                                           input logic mbit, input logic [31:0] n);
    logic [33:0] t;
    t = {1'b0, acc, 1'b0};
    if (t >= {2'b00, n}) t = t - {2'b00, n};
    if (mbit) t = t + {2'b00, a};
    if (t >= {2'b00, n}) t = t - {2'b00, n};
    return t[31:0];
  endfunction

  // Result multiply and base squaring share the multiplier bits of the current base.
  assign step_r   = mul_step(acc_r, r, b_q[cnt], n_q);
  assign step_b   = mul_step(acc_b, b_q, b_q[cnt], n_q);
  assign accept   = md_start && (state != MD_RUN);
  assign last_bit = (cnt == 5'd0) && (e_q[31:1] == 31'd0);
  assign md_end   = (state == MD_END);

  always_comb begin
    state_nxt = state;
    case (state)
      MD_IDLE, MD_END: begin
        if (md_start) state_nxt = (exp == 32'd0) ? MD_END : MD_RUN;
        else          state_nxt = MD_IDLE;
      end
      MD_RUN:  if (last_bit) state_nxt = MD_END;
      default: state_nxt = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= MD_IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      b_q   <= '0;
      e_q   <= '0;
      n_q   <= '0;
      r     <= '0;
      acc_r <= '0;
      acc_b <= '0;
      cnt   <= '0;
    end else if (accept) begin
      b_q   <= base;
      e_q   <= exp;
      n_q   <= modulus;
      r     <= (modulus == 32'd1) ? 32'd0 : 32'd1;
      acc_r <= '0;
      acc_b <= '0;
      cnt   <= 5'd31;
    end else if (state == MD_RUN) begin
      if (cnt == 5'd0) begin
        if (e_q[0]) r <= step_r;
        b_q   <= step_b;
        e_q   <= e_q >> 1;
        acc_r <= '0;
        acc_b <= '0;
        cnt   <= 5'd31;
      end else begin
        acc_r <= step_r;
        acc_b <= step_b;
        cnt   <= cnt - 5'd1;
      end
    end
  end

endmodule

module sender_rsa (
  input  logic        clk,
  input  logic        rstn,
  input  logic        gen,
  input  logic [31:0] v_in,
  input  logic [31:0] rand0,
  input  logic [31:0] rand1,
  input  logic [31:0] N,
  input  logic [31:0] priv_key,
  input  logic [31:0] msg0,
  input  logic [31:0] msg1,
  output logic [31:0] mod_res0,
  output logic [31:0] mod_res1,
  output logic        gen_end
);

  typedef enum logic [2:0] {IDLE, SUB, EXP0, EXP1, ADD, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] v_q, x0_q, x1_q, n_q, d_q, m0_q, m1_q, k0_q, k1_q, res0_q, res1_q;
  logic [31:0] d0, d1, md_base, md_r;
  logic        md_start, md_end;

  function automatic logic [31:0] sub_mod(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] n);
    logic [32:0] t;
    if (a >= b) t = {1'b0, a} - {1'b0, b};
    else        t = {1'b0, a} + {1'b0, n} - {1'b0, b};
    return t[31:0];
  endfunction

  function automatic logic [31:0] add_mod(input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] n);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= {1'b0, n}) s = s - {1'b0, n};
    return s[31:0];
  endfunction

  assign d0 = sub_mod(v_q, x0_q, n_q);
  assign d1 = sub_mod(v_q, x1_q, n_q);

  RL_binary u_exp (
    .clk      (clk),
    .rstn     (rstn),
    .md_start (md_start),
    .base     (md_base),
    .exp      (d_q),
    .modulus  (n_q),
    .r        (md_r),
    .md_end   (md_end)
  );

  always_comb begin
    state_nxt = state;
    md_start  = 1'b0;
    md_base   = d1;
    gen_end   = 1'b0;
    case (state)
      IDLE: if (gen) state_nxt = SUB;
      SUB: begin
        md_start  = 1'b1;
        md_base   = d0;
        state_nxt = EXP0;
      end
      EXP0: begin
        if (md_end) begin
          md_start  = 1'b1;
          state_nxt = EXP1;
        end
      end
      EXP1: if (md_end) state_nxt = ADD;
      ADD:  state_nxt = DONE;
      DONE: begin
        gen_end   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Results are cleared on every accepted gen so a held output never shows a stale round.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q    <= '0;
      x0_q   <= '0;
      x1_q   <= '0;
      n_q    <= '0;
      d_q    <= '0;
      m0_q   <= '0;
      m1_q   <= '0;
      k0_q   <= '0;
      k1_q   <= '0;
      res0_q <= '0;
      res1_q <= '0;
    end else begin
      if (state == IDLE && gen) begin
        v_q    <= v_in;
        x0_q   <= rand0;
        x1_q   <= rand1;
        n_q    <= N;
        d_q    <= priv_key;
        m0_q   <= msg0;
        m1_q   <= msg1;
        res0_q <= '0;
        res1_q <= '0;
      end
      if (state == EXP0 && md_end) k0_q <= md_r;
      if (state == EXP1 && md_end) k1_q <= md_r;
      if (state == ADD) begin
        res0_q <= add_mod(m0_q, k0_q, n_q);
        res1_q <= add_mod(m1_q, k1_q, n_q);
      end
    end
  end

`ifdef SENDER_RSA_HOLD_RESULT_EN
  assign mod_res0 = res0_q;
  assign mod_res1 = res1_q;
`else
  assign mod_res0 = (state == DONE) ? res0_q : 32'd0;
  assign mod_res1 = (state == DONE) ? res1_q : 32'd0;
`endif

endmodule

// File: tb/tb_sender_rsa.sv
// Scoreboard bench for sender_rsa: a plain-arithmetic OT model predicts each round, a monitor checks on gen_end.

module tb_sender_rsa;

  logic        clk = 1'b0;
  logic        rstn;
  logic        gen;
  logic [31:0] v_in, rand0, rand1, N, priv_key, msg0, msg1;
  logic [31:0] mod_res0, mod_res1;
  logic        gen_end;

  typedef struct {
    logic [31:0] r0;
    logic [31:0] r1;
    string       name;
  } expect_t;

  expect_t sb[$];
  expect_t cur;
  int      checks = 0;
  int      errors = 0;
  int      doneCount = 0;

  sender_rsa dut (
    .clk      (clk),
    .rstn     (rstn),
    .gen      (gen),
    .v_in     (v_in),
    .rand0    (rand0),
    .rand1    (rand1),
    .N        (N),
    .priv_key (priv_key),
    .msg0     (msg0),
    .msg1     (msg1),
    .mod_res0 (mod_res0),
    .mod_res1 (mod_res1),
    .gen_end  (gen_end)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] refModExp(input logic [31:0] b, input logic [31:0] e,
                                            input logic [31:0] n);
    longint unsigned m, res, bb;
    m   = n;
    res = 64'd1 % m;
    bb  = b;
    bb  = bb % m;
    for (int i = 0; i < 32; i++) begin
      if (e[i]) res = (res * bb) % m;
      bb = (bb * bb) % m;
    end
    return res[31:0];
  endfunction

  // m' = (m + (v - x)^d) mod N, all arithmetic done modulo N directly.
  function automatic logic [31:0] refMask(input logic [31:0] v, input logic [31:0] x,
                                          input logic [31:0] n, input logic [31:0] d,
                                          input logic [31:0] m);
    longint unsigned lv, lx, ln, lm, diff, k, out;
    lv   = v;
    lx   = x;
    ln   = n;
    lm   = m;
    diff = (lv + ln - lx) % ln;
    k    = refModExp(diff[31:0], d, n);
    out  = (lm + k) % ln;
    return out[31:0];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rstn === 1'b1 && gen_end === 1'b1) begin
      doneCount++;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_gen_end: got gen_end=1, expected no pending round");
      end else begin
        cur = sb.pop_front();
        checkOutput({cur.name, "/mod_res0"}, mod_res0, cur.r0);
        checkOutput({cur.name, "/mod_res1"}, mod_res1, cur.r1);
      end
    end
  end

  task automatic driveVec(input logic [31:0] v, input logic [31:0] x0, input logic [31:0] x1,
                          input logic [31:0] n, input logic [31:0] d, input logic [31:0] m0,
                          input logic [31:0] m1);
    v_in     = v;
    rand0    = x0;
    rand1    = x1;
    N        = n;
    priv_key = d;
    msg0     = m0;
    msg1     = m1;
  endtask

  task automatic scramble();
    driveVec($urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom);
  endtask

  task automatic pushExpect(input string name, input logic [31:0] r0, input logic [31:0] r1);
    expect_t e;
    e.r0   = r0;
    e.r1   = r1;
    e.name = name;
    sb.push_back(e);
  endtask

  task automatic waitDone(input string name, input int startCount, output bit ok);
    int budget = 0;
    while (doneCount == startCount && budget < 40000) begin
      @(negedge clk);
      #1;
      budget++;
    end
    ok = (doneCount != startCount);
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL %s/timeout: got %0d gen_end pulses, expected %0d", name,
               doneCount - startCount, 1);
      sb.delete();
    end
  endtask

  // Called at negedge+1; issues one round and checks the outputs one cycle after gen_end.
  task automatic applyStimulus(input string name, input logic [31:0] v, input logic [31:0] x0,
                               input logic [31:0] x1, input logic [31:0] n,
                               input logic [31:0] d, input logic [31:0] m0,
                               input logic [31:0] m1, input logic [31:0] r0,
                               input logic [31:0] r1, input bit holdGen);
    int start;
    bit ok;
    pushExpect(name, r0, r1);
    start = doneCount;
    driveVec(v, x0, x1, n, d, m0, m1);
    gen = 1'b1;
    @(negedge clk);
    #1;
    if (!holdGen) gen = 1'b0;
    scramble();
    waitDone(name, start, ok);
    gen = 1'b0;
    if (ok) begin
      @(negedge clk);
      #1;
`ifdef SENDER_RSA_HOLD_RESULT_EN
      checkOutput({name, "/held0"}, mod_res0, r0);
      checkOutput({name, "/held1"}, mod_res1, r1);
`else
      checkOutput({name, "/cleared0"}, mod_res0, 32'd0);
      checkOutput({name, "/cleared1"}, mod_res1, 32'd0);
`endif
    end
  endtask

  initial begin
    logic [31:0] n, d, v, x0, x1, m0, m1, c, r0, r1;
    int start;
    bit ok;

    rstn = 1'b0;
    gen  = 1'b0;
    driveVec(0, 0, 0, 0, 0, 0, 0);
    #12;
    checkOutput("reset/gen_end", {31'd0, gen_end}, 32'd0);
    checkOutput("reset/mod_res0", mod_res0, 32'd0);
    checkOutput("reset/mod_res1", mod_res1, 32'd0);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    #1;

    applyStimulus("wrap", 10, 4, 20, 33, 1, 5, 30, 11, 20, 1'b0);
    repeat (9) begin
      @(negedge clk);
      #1;
    end
`ifdef SENDER_RSA_HOLD_RESULT_EN
    checkOutput("hold10/mod_res0", mod_res0, 32'd11);
`else
    checkOutput("clear10/mod_res0", mod_res0, 32'd0);
`endif

    applyStimulus("zero_key", 5, 3, 5, 33, 7, 10, 9, 6, 9, 1'b0);

    c  = refModExp(32'd42, 32'd17, 32'd3233);
    v  = (c + 32'd100 >= 32'd3233) ? c + 32'd100 - 32'd3233 : c + 32'd100;
    x1 = $urandom % 32'd3233;
    m1 = $urandom % 32'd3233;
    r1 = refMask(v, x1, 32'd3233, 32'd2753, m1);
    applyStimulus("ot_round", v, 100, x1, 3233, 2753, 1000, m1, 1042, r1, 1'b0);

    start = doneCount;
    applyStimulus("gen_held", 10, 4, 20, 33, 1, 5, 30, 11, 20, 1'b1);
    repeat (200) @(negedge clk);
    #1;
    checkOutput("gen_held/pulse_count", doneCount - start, 32'd1);

    // A gen during DONE must be dropped; the one in the following IDLE cycle starts the next round.
    start = doneCount;
    pushExpect("b2b_a", 11, 20);
    driveVec(10, 4, 20, 33, 1, 5, 30);
    gen = 1'b1;
    @(negedge clk);
    #1;
    gen = 1'b0;
    waitDone("b2b_a", start, ok);
    pushExpect("b2b_b", 6, 9);
    driveVec(5, 3, 5, 33, 7, 10, 9);
    gen = 1'b1;
    @(negedge clk);
    #1;
    @(negedge clk);
    #1;
    gen = 1'b0;
    waitDone("b2b_b", start + 1, ok);
    repeat (300) @(negedge clk);
    #1;
    checkOutput("b2b/pulse_count", doneCount - start, 32'd2);

    // Abort a long exponentiation with an asynchronous reset mid-EXP0.
    driveVec(v, 100, x1, 3233, 2753, 1000, m1);
    gen = 1'b1;
    @(negedge clk);
    #1;
    gen = 1'b0;
    repeat (20) @(negedge clk);
    #2;
    rstn = 1'b0;
    #1;
    checkOutput("abort/gen_end", {31'd0, gen_end}, 32'd0);
    checkOutput("abort/mod_res0", mod_res0, 32'd0);
    checkOutput("abort/mod_res1", mod_res1, 32'd0);
    @(negedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    #1;
    applyStimulus("after_abort", 10, 4, 20, 33, 1, 5, 30, 11, 20, 1'b0);

    for (int i = 0; i < 12; i++) begin
      n = (i % 2 == 0) ? $urandom : $urandom_range(1000, 2);
      if (n < 32'd2) n = 32'd2;
      v  = $urandom % n;
      x0 = (i == 3) ? v : $urandom % n;
      x1 = (i == 5) ? v : $urandom % n;
      m0 = $urandom % n;
      m1 = $urandom % n;
      d  = $urandom_range(65535, 1);
      r0 = refMask(v, x0, n, d, m0);
      r1 = refMask(v, x1, n, d, m1);
      applyStimulus($sformatf("rand%0d", i), v, x0, x1, n, d, m0, m1, r0, r1, 1'b0);
    end

    repeat (5) @(negedge clk);
    checkOutput("scoreboard/empty", sb.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sender_rsa.md
SENDER_RSA -- requirements
Module: sender_rsa

Interface
REQ-001 The block SHALL have no parameters; all datapaths SHALL be fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rstn  input  1  reset, asynchronous, active-low.
REQ-004 gen  input  1  start request, sampled in IDLE only.
REQ-005 v_in  input  32  receiver's blinded value v.
REQ-006 rand0, rand1  input  32 each  sender random values x0, x1 previously sent to the receiver.
REQ-007 N  input  32  RSA modulus.
REQ-008 priv_key  input  32  RSA private exponent d.
REQ-009 msg0, msg1  input  32 each  sender messages m0, m1; each SHALL be < N.
REQ-010 mod_res0, mod_res1  output  32 each  masked messages m0', m1'.
REQ-011 gen_end  output  1  completion strobe.

Function
REQ-012 The block SHALL compute k0 = (v - x0)^d mod N, k1 = (v - x1)^d mod N, m0' = (m0 + k0) mod N and m1' = (m1 + k1) mod N, with inputs v, x0 and x1 < N.
REQ-013 The block SHALL instantiate exactly one RL_binary modular exponentiator (ports clk, rstn, md_start, base, exp, modulus, r, md_end) and use it twice in sequence.
REQ-014 The FSM states SHALL be IDLE, SUB, EXP0, EXP1, ADD and DONE.
REQ-015 IDLE: on gen=1, the block SHALL latch v_in, rand0, rand1, N, priv_key, msg0 and msg1 into internal registers and go to SUB; later input changes SHALL have no effect until the next accepted gen.
REQ-016 SUB: the block SHALL compute d0 = v - x0 if v >= x0, else v + N - x0, using a 33-bit intermediate; it SHALL compute d1 the same way from x1.
REQ-017 SUB: the block SHALL drive md_start=1 for exactly one cycle with base=d0 and exp=d, then go to EXP0.
REQ-018 EXP0: on md_end, the block SHALL store k0, pulse md_start for one cycle with base=d1 and exp=d, and go to EXP1; md_start SHALL be 0 otherwise.
REQ-019 EXP1: on md_end, the block SHALL store k1 and go to ADD.
REQ-020 ADD: for each i, the block SHALL form s = mi + ki in 33 bits and store s - N if s >= N, else s; then go to DONE.
REQ-021 DONE: the block SHALL assert gen_end for exactly one cycle and present m0' on mod_res0 and m1' on mod_res1; the next state SHALL be IDLE.
REQ-022 Total latency from gen to gen_end SHALL be 3 + L0 + L1 cycles, where L0 and L1 are the RL_binary md_start-to-md_end latencies.
REQ-023 A gen that arrives in any state other than IDLE SHALL be ignored and SHALL NOT be queued.
REQ-024 A gen in the same cycle as DONE SHALL be ignored; a gen on the cycle after DONE (IDLE) SHALL be accepted.
REQ-025 If v equals xi, then di SHALL be 0 and ki SHALL be 0 (for d > 0), so mi' = mi.
REQ-026 Unreachable state encodings SHALL return to IDLE with md_start=0.

Reset
REQ-027 rstn=0 SHALL immediately force state=IDLE, md_start=0, gen_end=0, mod_res0=0 and mod_res1=0, regardless of the clock.
REQ-028 The same rstn SHALL drive RL_binary, so a reset mid-operation aborts any exponentiation in progress.
REQ-029 After reset deassertion, the first accepted gen SHALL start a fresh computation with no residue from the aborted one.

Configuration
REQ-030 The macro SENDER_RSA_HOLD_RESULT_EN SHALL control output holding.
REQ-031 Without SENDER_RSA_HOLD_RESULT_EN, mod_res0 and mod_res1 SHALL be 0 in every state except DONE.
REQ-032 With SENDER_RSA_HOLD_RESULT_EN, mod_res0 and mod_res1 SHALL hold the last DONE values until the next accepted gen or reset, and gen_end SHALL remain a one-cycle strobe.

Verification
REQ-033 N=33, d=1, v=10, x0=4, x1=20, m0=5, m1=30 -> mod_res0=11 and mod_res1=20 in the gen_end cycle; this covers subtraction wrap and addition wrap.
REQ-034 N=33, d=7, v=5, x0=3, x1=5, m0=10, m1=9 -> k0=29, mod_res0=6; k1=0, mod_res1=9.
REQ-035 Full OT round with N=3233, d=2753, k=42, selection b=0, x0=100, v=(42^17 + 100) mod 3233, m0=1000 -> mod_res0=1042.
REQ-036 gen held high for the whole operation plus a gen pulse during EXP1 -> exactly one gen_end, with results unchanged.
REQ-037 rstn pulsed low during EXP0 -> outputs 0 and state IDLE immediately; a following gen with the REQ-033 vector -> 11/20.
REQ-038 With SENDER_RSA_HOLD_RESULT_EN defined, the REQ-033 vector -> mod_res0=11 still present 10 cycles after gen_end; without the macro -> 0 one cycle after gen_end.
